// File: rtl/note_event_generator.sv
// note_event_generator
// Turns raw keyboard switches and octave buttons into note events.
// Each of the 14 raw inputs is synchronised and debounced. The 12 note keys
// are then priority-encoded (lowest pressed key wins). A saturating octave
// register follows the debounced octave buttons. A small FSM emits a
// one-cycle note_in strobe whenever the sounding note or octave changes.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no debounced key held; note/octave keep their last values
// EMIT  | note_in high for this single cycle; note/octave valid
// HELD  | key held, event already issued; watching for note/octave change
module note_event_generator #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19,
  parameter int OCT_RESET       = 4,
  parameter int OCT_MAX         = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] keys,
  input  logic        oct_up,
  input  logic        oct_down,
  output logic        note_in,
  output logic [3:0]  note,
  output logic [2:0]  octave,
  output logic        note_active
);

  localparam int N_IN = 14;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [2:0]       OCT_RST_V = 3'(OCT_RESET);
  localparam logic [2:0]       OCT_MAX_V = 3'(OCT_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    HELD = 2'd2
  } state_t;

  state_t            state;
  logic [N_IN-1:0]   raw;
  logic [N_IN-1:0]   sync1;
  logic [N_IN-1:0]   sync2;
  logic [N_IN-1:0]   deb;
  logic [CNT_W-1:0]  cnt [N_IN];
  logic [1:0]        btn_d;     // previous debounced {oct_down, oct_up}
  logic [3:0]        sel;
  logic              any;
  logic              up_rise;
  logic              dn_rise;
  logic [2:0]        oct_next;
  logic              oct_chg;
  logic              oct_pend;  // octave moved while in EMIT; retrigger from HELD

  // Bits 0..11 are the note keys, 12 is octave-up, 13 is octave-down.
  assign raw = {oct_down, oct_up, keys};

  // Two-flop synchroniser for every raw input.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Per-input debounce: accept a new level only after it has differed from
  // the debounced level for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      deb <= '0;
      for (int i = 0; i < N_IN; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end
      end
    end
  end

  // Lowest pressed key wins; scanning downward lets the lowest index land last.
  always_comb begin
    sel = 4'd0;
    for (int i = 11; i >= 0; i--) begin
      if (deb[i]) begin
        sel = 4'(i);
      end
    end
    any = |deb[11:0];
  end

  assign up_rise = deb[12] & ~btn_d[0];
  assign dn_rise = deb[13] & ~btn_d[1];

  // Next octave from debounced button edges; simultaneous edges cancel and
  // a press that hits a limit leaves the value (and therefore oct_chg) alone.
  always_comb begin
    oct_next = octave;
    if (up_rise && !dn_rise && (octave != OCT_MAX_V)) begin
      oct_next = octave + 3'd1;
    end else if (dn_rise && !up_rise && (octave != 3'd0)) begin
      oct_next = octave - 3'd1;
    end
    oct_chg = (oct_next != octave);
  end

  // Octave register and button edge history.
  always_ff @(posedge clk) begin
    if (reset) begin
      octave <= OCT_RST_V;
      btn_d  <= '0;
    end else begin
      octave <= oct_next;
      btn_d  <= deb[13:12];
    end
  end

  // Event FSM with registered strobe, note and activity outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      note        <= 4'd0;
      note_in     <= 1'b0;
      note_active <= 1'b0;
      oct_pend    <= 1'b0;
    end else begin
      note_in  <= 1'b0;
      oct_pend <= 1'b0;
      case (state)
        IDLE: begin
          if (any) begin
            note        <= sel;
            state       <= EMIT;
            note_in     <= 1'b1;
            note_active <= 1'b1;
          end else begin
            note_active <= 1'b0;
          end
        end
        EMIT: begin
          // An octave step landing here is remembered and replayed from HELD.
          state       <= HELD;
          note_active <= 1'b1;
          oct_pend    <= oct_chg;
        end
        HELD: begin
          if (!any) begin
            state       <= IDLE;
            note_active <= 1'b0;
          end else if ((sel != note) || oct_chg || oct_pend) begin
            note        <= sel;
            state       <= EMIT;
            note_in     <= 1'b1;
            note_active <= 1'b1;
          end else begin
            note_active <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          note_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_note_event_generator.sv
// Testbench for note_event_generator with a short debounce window.
module tb_note_event_generator;

  localparam int DB      = 4;
  localparam int OCT_RST = 4;
  localparam int OCT_TOP = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] keys = '0;
  logic        oct_up = 1'b0;
  logic        oct_down = 1'b0;
  logic        note_in;
  logic [3:0]  note;
  logic [2:0]  octave;
  logic        note_active;

  note_event_generator #(
    .DEBOUNCE_CYCLES(DB),
    .CNT_W(4),
    .OCT_RESET(OCT_RST),
    .OCT_MAX(OCT_TOP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .keys(keys),
    .oct_up(oct_up),
    .oct_down(oct_down),
    .note_in(note_in),
    .note(note),
    .octave(octave),
    .note_active(note_active)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int strobe_cnt = 0;
  int prev_strobe = 0;

  // ---------------- behavioural reference model ----------------
  // Inputs are tracked as plain integer histories: a 2-cycle delay line, then
  // a "how long has it disagreed" run length that flips the clean level once
  // the disagreement has lasted DB cycles. Events follow the note/octave rules.
  int s1 [14];
  int s2 [14];
  int db [14];
  int db_prev [14];
  int run [14];
  int m_oct, m_note, m_strobe, m_active, m_pend;

  task automatic model_reset();
    for (int i = 0; i < 14; i++) begin
      s1[i] = 0; s2[i] = 0; db[i] = 0; db_prev[i] = 0; run[i] = 0;
    end
    m_oct = OCT_RST; m_note = 0; m_strobe = 0; m_active = 0; m_pend = 0;
  endtask

  task automatic model_step(input logic [13:0] r, input bit rst);
    int any_k, lowest, up_e, dn_e, new_oct, chg, was_strobe;
    if (rst) begin
      model_reset();
      return;
    end
    any_k = 0; lowest = 0;
    for (int i = 11; i >= 0; i--) if (db[i] != 0) begin any_k = 1; lowest = i; end
    up_e = (db[12] != 0 && db_prev[12] == 0);
    dn_e = (db[13] != 0 && db_prev[13] == 0);
    new_oct = m_oct;
    if (up_e && !dn_e) new_oct = (m_oct < OCT_TOP) ? m_oct + 1 : m_oct;
    if (dn_e && !up_e) new_oct = (m_oct > 0) ? m_oct - 1 : m_oct;
    chg = (new_oct != m_oct);
    was_strobe = m_strobe;
    if (was_strobe) begin
      m_strobe = 0;
      m_pend = chg;
    end else if (!m_active) begin
      m_pend = 0;
      if (any_k) begin m_strobe = 1; m_note = lowest; m_active = 1; end
    end else if (!any_k) begin
      m_pend = 0; m_active = 0;
    end else if (lowest != m_note || chg || m_pend) begin
      m_pend = 0; m_strobe = 1; m_note = lowest;
    end else begin
      m_pend = 0;
    end
    m_oct = new_oct;
    for (int i = 0; i < 14; i++) begin
      db_prev[i] = db[i];
      if (s2[i] != db[i]) begin
        run[i]++;
        if (run[i] == DB) begin db[i] = s2[i]; run[i] = 0; end
      end else begin
        run[i] = 0;
      end
      s2[i] = s1[i];
      s1[i] = int'(r[i]);
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic cycle(input logic [11:0] k, input logic u, input logic d, input logic rst);
    @(negedge clk);
    keys = k; oct_up = u; oct_down = d; reset = rst;
    @(posedge clk);
    #1;
    model_step({d, u, k}, rst);
    chk("model_note_in", int'(note_in), m_strobe);
    chk("model_note", int'(note), m_note);
    chk("model_octave", int'(octave), m_oct);
    chk("model_active", int'(note_active), m_active);
    chk("no_double_strobe", (prev_strobe != 0 && note_in) ? 1 : 0, 0);
    prev_strobe = int'(note_in);
    if (note_in) strobe_cnt++;
  endtask

  typedef struct {
    logic [11:0] k;
    logic        u;
    logic        d;
    int          cycles;
    int          strobes;
    int          e_note;
    int          e_oct;
    int          e_active;
  } seg_t;

  seg_t tbl [21];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, second, pos;

    tbl[0]  = '{12'h000, 1'b0, 1'b0, 10, 0, 0, 4, 0};
    tbl[1]  = '{12'h200, 1'b0, 1'b0, 12, 1, 9, 4, 1};
    tbl[2]  = '{12'h204, 1'b0, 1'b0, 12, 1, 2, 4, 1};
    tbl[3]  = '{12'h200, 1'b0, 1'b0, 12, 1, 9, 4, 1};
    tbl[4]  = '{12'h000, 1'b0, 1'b0, 12, 0, 9, 4, 0};
    tbl[5]  = '{12'h020, 1'b0, 1'b0,  3, 0, 9, 4, 0};
    tbl[6]  = '{12'h000, 1'b0, 1'b0, 12, 0, 9, 4, 0};
    tbl[7]  = '{12'h001, 1'b0, 1'b0, 12, 1, 0, 4, 1};
    tbl[8]  = '{12'h001, 1'b1, 1'b0, 12, 1, 0, 5, 1};
    tbl[9]  = '{12'h001, 1'b0, 1'b0, 12, 0, 0, 5, 1};
    tbl[10] = '{12'h001, 1'b1, 1'b0, 12, 1, 0, 6, 1};
    tbl[11] = '{12'h001, 1'b0, 1'b0, 12, 0, 0, 6, 1};
    tbl[12] = '{12'h001, 1'b1, 1'b0, 12, 0, 0, 6, 1};
    tbl[13] = '{12'h001, 1'b0, 1'b0, 12, 0, 0, 6, 1};
    tbl[14] = '{12'h001, 1'b1, 1'b1, 12, 0, 0, 6, 1};
    tbl[15] = '{12'h001, 1'b0, 1'b0, 12, 0, 0, 6, 1};
    tbl[16] = '{12'h000, 1'b0, 1'b1, 12, 0, 0, 5, 0};
    tbl[17] = '{12'h000, 1'b0, 1'b0, 12, 0, 0, 5, 0};
    tbl[18] = '{12'h800, 1'b0, 1'b0, 12, 1, 11, 5, 1};
    tbl[19] = '{12'h800, 1'b0, 1'b1, 12, 1, 11, 4, 1};
    tbl[20] = '{12'h000, 1'b0, 1'b0, 12, 0, 11, 4, 0};

    model_reset();
    cycle(12'h000, 1'b0, 1'b0, 1'b1);
    cycle(12'h000, 1'b0, 1'b0, 1'b1);
    chk("reset_octave", int'(octave), 4);
    chk("reset_note", int'(note), 0);
    chk("reset_active", int'(note_active), 0);
    chk("reset_note_in", int'(note_in), 0);

    // Table-driven segments
    for (int s = 0; s < 21; s++) begin
      strobe_cnt = 0;
      for (int c = 0; c < tbl[s].cycles; c++) cycle(tbl[s].k, tbl[s].u, tbl[s].d, 1'b0);
      chk($sformatf("seg%0d_strobes", s), strobe_cnt, tbl[s].strobes);
      chk($sformatf("seg%0d_note", s), int'(note), tbl[s].e_note);
      chk($sformatf("seg%0d_octave", s), int'(octave), tbl[s].e_oct);
      chk($sformatf("seg%0d_active", s), int'(note_active), tbl[s].e_active);
    end

    // Key press to strobe latency: 2 sync + DB debounce + 1 emit cycles
    first = -1; strobe_cnt = 0;
    for (int c = 1; c <= 12; c++) begin
      cycle(12'h008, 1'b0, 1'b0, 1'b0);
      if (note_in && first < 0) first = c;
    end
    chk("latency_cycles", first, 2 + DB + 1);
    chk("latency_strobes", strobe_cnt, 1);
    chk("latency_note", int'(note), 3);
    for (int c = 0; c < 12; c++) cycle(12'h000, 1'b0, 1'b0, 1'b0);

    // Octave step landing during EMIT: retrigger two cycles after the first strobe
    first = -1; second = -1; strobe_cnt = 0;
    cycle(12'h040, 1'b0, 1'b0, 1'b0);
    for (int c = 2; c <= 14; c++) begin
      cycle(12'h040, 1'b1, 1'b0, 1'b0);
      if (note_in) begin
        if (first < 0) first = c; else if (second < 0) second = c;
      end
    end
    chk("emit_oct_first", first, 7);
    chk("emit_oct_second", second, 9);
    chk("emit_oct_strobes", strobe_cnt, 2);
    chk("emit_oct_octave", int'(octave), 5);
    for (int c = 0; c < 12; c++) cycle(12'h000, 1'b0, 1'b0, 1'b0);

    // Reset while a key is held: immediate clear, then a fresh event
    for (int c = 0; c < 12; c++) cycle(12'h010, 1'b0, 1'b0, 1'b0);
    chk("pre_reset_active", int'(note_active), 1);
    cycle(12'h010, 1'b0, 1'b0, 1'b1);
    chk("rst_hold_note_in", int'(note_in), 0);
    chk("rst_hold_note", int'(note), 0);
    chk("rst_hold_octave", int'(octave), 4);
    chk("rst_hold_active", int'(note_active), 0);
    pos = -1; strobe_cnt = 0;
    for (int c = 1; c <= 12; c++) begin
      cycle(12'h010, 1'b0, 1'b0, 1'b0);
      if (note_in && pos < 0) begin
        pos = c;
        chk("rst_hold_strobe_note", int'(note), 4);
        chk("rst_hold_strobe_octave", int'(octave), 4);
      end
    end
    chk("rst_hold_latency", pos, 7);
    chk("rst_hold_strobes", strobe_cnt, 1);

    // Randomised stimulus against the reference model
    for (int s = 0; s < 200; s++) begin
      logic [11:0] k;
      logic u, d, r;
      int len;
      case ($urandom_range(0, 3))
        0: k = '0;
        1: k = 12'(1) << $urandom_range(0, 11);
        2: k = (12'(1) << $urandom_range(0, 11)) | (12'(1) << $urandom_range(0, 11));
        default: k = 12'($urandom);
      endcase
      u = ($urandom_range(0, 3) == 0);
      d = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 59) == 0);
      len = $urandom_range(1, 12);
      if (r) cycle(k, u, d, 1'b1);
      for (int c = 0; c < len; c++) cycle(k, u, d, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
